// File: rtl/fifo_vc_arbiter_if.sv
// FIFO-side bus of the VC arbiter: input FIFO bank flags/heads, output FIFO
// bank flags, and the strobes/data the arbiter drives back to both banks.
interface fifo_vc_arbiter_if #(
  parameter int DATA_SIZE = 6
);
  logic [3:0]           in_empty;
  logic [DATA_SIZE-1:0] in_data0;
  logic [DATA_SIZE-1:0] in_data1;
  logic [DATA_SIZE-1:0] in_data2;
  logic [DATA_SIZE-1:0] in_data3;
  logic [3:0]           out_full;
  logic [3:0]           out_pause;
  logic [3:0]           pop;
  logic [3:0]           push;
  logic [DATA_SIZE-1:0] data_out;

  // Arbiter side
  modport master (
    input  in_empty, in_data0, in_data1, in_data2, in_data3,
    input  out_full, out_pause,
    output pop, push, data_out
  );

  // FIFO bank side
  modport slave (
    output in_empty, in_data0, in_data1, in_data2, in_data3,
    output out_full, out_pause,
    input  pop, push, data_out
  );
endinterface

// File: rtl/fifo_vc_arbiter.sv
// Round-robin (or fixed-priority) mover from four input FIFOs to four output
// FIFOs. One transfer every three cycles: IDLE arbitrates, XFER holds the
// strobes for one cycle, HOLD lets FIFO flags and head words settle.
module fifo_vc_arbiter #(
  parameter int DATA_SIZE   = 6,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  fifo_vc_arbiter_if.master   bus,
  output logic [1:0]          grant_ch,
  output logic                busy,
  output logic [7:0]          xfer_count
);

  typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

  state_t               state_q, state_d;
  logic [3:0]           pop_q, pop_d;
  logic [3:0]           push_q, push_d;
  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic [1:0]           grant_ch_q, grant_ch_d;
  logic [1:0]           last_grant_q, last_grant_d;
  logic [7:0]           xfer_count_q, xfer_count_d;

  logic [DATA_SIZE-1:0] in_data [4];
  logic [1:0]           dest [4];
  logic [3:0]           eligible;
  logic                 found;
  logic [1:0]           win;
  logic [1:0]           cand;

  assign in_data[0] = bus.in_data0;
  assign in_data[1] = bus.in_data1;
  assign in_data[2] = bus.in_data2;
  assign in_data[3] = bus.in_data3;

  // Destination decode and per-input eligibility against the output flags
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dest[i]     = in_data[i][DATA_SIZE-1 -: 2];
      eligible[i] = !bus.in_empty[i] && !bus.out_full[dest[i]] && !bus.out_pause[dest[i]];
    end
  end

  // Pick the first eligible input in search order; blocked inputs are skipped
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    cand  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ROUND_ROBIN ? 2'(last_grant_q + 2'(k + 1)) : 2'(k);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/XFER/HOLD cycle
  always_comb begin
    state_d      = state_q;
    pop_d        = 4'b0000;
    push_d       = 4'b0000;
    data_out_d   = data_out_q;
    grant_ch_d   = grant_ch_q;
    last_grant_d = last_grant_q;
    xfer_count_d = xfer_count_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = XFER;
          pop_d        = 4'b0001 << win;
          push_d       = 4'b0001 << dest[win];
          data_out_d   = in_data[win];
          grant_ch_d   = win;
          last_grant_d = win;
        end
      end
      XFER: begin
        state_d      = HOLD;
        xfer_count_d = xfer_count_q + 8'd1;
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset parks the rotation so ch0 is searched first
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pop_q        <= 4'b0000;
      push_q       <= 4'b0000;
      data_out_q   <= '0;
      grant_ch_q   <= 2'd0;
      last_grant_q <= 2'd3;
      xfer_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      pop_q        <= pop_d;
      push_q       <= push_d;
      data_out_q   <= data_out_d;
      grant_ch_q   <= grant_ch_d;
      last_grant_q <= last_grant_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign bus.pop      = pop_q;
  assign bus.push     = push_q;
  assign bus.data_out = data_out_q;
  assign grant_ch     = grant_ch_q;
  assign busy         = (state_q == XFER) || (state_q == HOLD);
  assign xfer_count   = xfer_count_q;

endmodule
